avmm_cmd_master: RTL and testbench
==================================

Name: avmm_cmd_master

Overview:
Single-outstanding Avalon-MM initiator that turns a simple valid/ready command stream into one bus read or write toward PIO-style slaves, using chipselect, active-low write_n/read_n and optional waitrequest. Read data is sampled when the transfer completes, which matches zero-latency slaves whose readdata is combinational from address. It returns one response per command and reports bus hangs through a timeout. It sits between the control sequencer or debug logic and the system PIO and control-register slaves.

Parameters:
ADDR_W, 2, width of cmd_address and avm_address (word address)
DATA_W, 32, width of write and read data
TIMEOUT, 255, max cycles in ACCESS before abort; legal range 1..65535

Ports:
clk  in  1  system clock
reset_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_address  in  ADDR_W  target word address
cmd_writedata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_readdata  out  DATA_W  read data; 0 for writes and errors
rsp_error  out  1  qualifies rsp_valid; 1 = timeout
avm_address  out  ADDR_W  bus address
avm_chipselect  out  1  bus select
avm_write_n  out  1  active-low write strobe
avm_read_n  out  1  active-low read strobe
avm_writedata  out  DATA_W  bus write data
avm_readdata  in  DATA_W  bus read data
avm_waitrequest  in  1  slave stall; tie 0 for no-wait slaves

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_readdata=0, avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0, timeout counter=0.
- All outputs are registered. cmd_ready is 1 exactly when state is IDLE.
- IDLE: if cmd_valid is 1 (handshake), latch write/address/data into the bus registers, set chipselect=1, set write_n=~cmd_write and read_n=cmd_write, clear the counter, go to ACCESS.
- ACCESS: bus signals are held stable. The counter increments each cycle.
  - If avm_waitrequest is 0, the transfer completes this cycle: for a read, capture avm_readdata into rsp_readdata; for a write, rsp_readdata=0. rsp_error=0. Deassert the bus (chipselect=0, strobes=1) and go to RESP.
  - Otherwise, if counter==TIMEOUT-1 (i.e. the TIMEOUT-th stalled cycle), abort: rsp_error=1, rsp_readdata=0, deassert the bus, go to RESP.
  - If completion and timeout fall in the same cycle, completion wins and rsp_error=0.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure; the consumer must accept the pulse.
- Latency with no waits: handshake in cycle N; bus active in cycle N+1; rsp_valid in cycle N+2; cmd_ready high again in N+3. Peak throughput is one command per 3 cycles.
- With W wait cycles, rsp_valid appears in cycle N+2+W.
- Commands presented while cmd_ready=0 are ignored and stay pending. cmd_* inputs may change freely outside the handshake cycle.
- Reset asserted mid-ACCESS: the bus deasserts immediately (asynchronously), no response is issued, and the in-flight command is dropped.
- The counter is wide enough for TIMEOUT (ceil log2) and never wraps; it is cleared on entry to ACCESS.
- Address and data are passed through unchanged; there is no width conversion.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and a default timeout constant.
- Timeout counter as sub-module avmm_timeout_ctr (clear, enable, expire output).
- The FSM and datapath stay in the top module.

Test Plan:
- Write with waitrequest=0, address=0, data=32'h0000_00A5, against a PIO output slave model (reset value 8'hFF) -> one bus cycle with write_n=0 at N+1; rsp_valid at N+2 with rsp_error=0; slave out_port=8'hA5.
- Read address 0 after that write -> read_n=0 at N+1; rsp_readdata=32'h0000_00A5; rsp_valid at N+2. Read address 1 -> rsp_readdata=0.
- waitrequest held 3 cycles during a write -> bus signals stable for 4 cycles; rsp_valid at N+5; the slave latches exactly once.
- TIMEOUT=4 with waitrequest stuck at 1 -> exactly 4 ACCESS cycles, then bus released; rsp_valid with rsp_error=1 and rsp_readdata=0; the next command is accepted normally.
- Back-to-back: cmd_valid held high with 3 commands -> handshakes every 3rd cycle; 3 responses in order with the correct data.
- reset_n pulsed low during ACCESS -> chipselect=0 and write_n=read_n=1 immediately; no rsp_valid; cmd_ready=1 after release.

Source files
------------

// File: rtl/avmm_cmd_master_pkg.sv
// Shared definitions for the Avalon-MM command master: FSM encoding and
// the default bus-hang timeout.
package avmm_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/avmm_timeout_ctr.sv
// Saturating cycle counter for the ACCESS phase; o_expire flags the
// TIMEOUT-th cycle since the last clear.
module avmm_timeout_ctr
  import avmm_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expire;

  assign w_expire = (r_count == LAST);
  assign o_expire = w_expire;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/avmm_cmd_master.sv
// Single-outstanding Avalon-MM initiator: one valid/ready command becomes one
// bus read or write, answered by a one-cycle response pulse.
module avmm_cmd_master
  import avmm_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  state_t            r_state, w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_error, w_rsp_error_nxt;
  logic [DATA_W-1:0] r_rsp_readdata, w_rsp_readdata_nxt;
  logic [ADDR_W-1:0] r_avm_address, w_avm_address_nxt;
  logic              r_avm_cs, w_avm_cs_nxt;
  logic              r_avm_write_n, w_avm_write_n_nxt;
  logic              r_avm_read_n, w_avm_read_n_nxt;
  logic [DATA_W-1:0] r_avm_writedata, w_avm_writedata_nxt;
  logic              w_handshake, w_done, w_expire;

  assign w_handshake = (r_state == ST_IDLE) && cmd_valid;
  assign w_done      = (r_state == ST_ACCESS) && (!avm_waitrequest || w_expire);

  avmm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_handshake),
    .i_enable (r_state == ST_ACCESS),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_done)    w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_cmd_ready_nxt     = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt     = 1'b0;
    w_rsp_error_nxt     = r_rsp_error;
    w_rsp_readdata_nxt  = r_rsp_readdata;
    w_avm_address_nxt   = r_avm_address;
    w_avm_cs_nxt        = r_avm_cs;
    w_avm_write_n_nxt   = r_avm_write_n;
    w_avm_read_n_nxt    = r_avm_read_n;
    w_avm_writedata_nxt = r_avm_writedata;
    if (w_handshake) begin
      w_avm_address_nxt   = cmd_address;
      w_avm_writedata_nxt = cmd_writedata;
      w_avm_cs_nxt        = 1'b1;
      w_avm_write_n_nxt   = ~cmd_write;
      w_avm_read_n_nxt    = cmd_write;
    end
    if (w_done) begin
      // Completion beats a coinciding timeout; reads sample the slave now.
      w_rsp_valid_nxt    = 1'b1;
      w_rsp_error_nxt    = avm_waitrequest;
      w_rsp_readdata_nxt = (!avm_waitrequest && !r_avm_read_n) ? avm_readdata : '0;
      w_avm_cs_nxt       = 1'b0;
      w_avm_write_n_nxt  = 1'b1;
      w_avm_read_n_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_error     <= 1'b0;
      r_rsp_readdata  <= '0;
      r_avm_address   <= '0;
      r_avm_cs        <= 1'b0;
      r_avm_write_n   <= 1'b1;
      r_avm_read_n    <= 1'b1;
      r_avm_writedata <= '0;
    end else begin
      r_cmd_ready     <= w_cmd_ready_nxt;
      r_rsp_valid     <= w_rsp_valid_nxt;
      r_rsp_error     <= w_rsp_error_nxt;
      r_rsp_readdata  <= w_rsp_readdata_nxt;
      r_avm_address   <= w_avm_address_nxt;
      r_avm_cs        <= w_avm_cs_nxt;
      r_avm_write_n   <= w_avm_write_n_nxt;
      r_avm_read_n    <= w_avm_read_n_nxt;
      r_avm_writedata <= w_avm_writedata_nxt;
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_error      = r_rsp_error;
  assign rsp_readdata   = r_rsp_readdata;
  assign avm_address    = r_avm_address;
  assign avm_chipselect = r_avm_cs;
  assign avm_write_n    = r_avm_write_n;
  assign avm_read_n     = r_avm_read_n;
  assign avm_writedata  = r_avm_writedata;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master against a small PIO slave model
// (8-bit output register at address 0, reset value 8'hFF).
module tb_avmm_cmd_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_readdata;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n, avm_read_n;
  logic [31:0] avm_writedata, avm_readdata;
  logic        waitreq;

  int checks = 0;
  int errors = 0;

  logic [7:0] pio_out = 8'hFF;
  int         pio_writes = 0;

  always #5 clk = ~clk;

  avmm_cmd_master #(.ADDR_W(2), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_address     (cmd_address),
    .cmd_writedata   (cmd_writedata),
    .rsp_valid       (rsp_valid),
    .rsp_readdata    (rsp_readdata),
    .rsp_error       (rsp_error),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_read_n      (avm_read_n),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (waitreq)
  );

  // PIO slave: zero-latency readback, write accepted only when not stalled.
  assign avm_readdata = (avm_address == 2'd0) ? {24'h0, pio_out} : 32'h0;

  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n && !waitreq) begin
      if (avm_address == 2'd0) pio_out <= avm_writedata[7:0];
      pio_writes <= pio_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command with no wait states; checks cycles N, N+1, N+2, N+3.
  task automatic run_cmd(input logic wr, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_writedata = wd;
    tick();
    cmd_valid = 1'b0; cmd_writedata = 32'hDEAD_BEEF; cmd_address = ~addr;
    check("bus_cs", avm_chipselect, 1);
    check("bus_write_n", avm_write_n, {31'h0, ~wr});
    check("bus_read_n", avm_read_n, {31'h0, wr});
    check("bus_addr", avm_address, {30'h0, addr});
    if (wr) check("bus_wdata", avm_writedata, wd);
    check("busy_ready", cmd_ready, 0);
    check("early_rsp", rsp_valid, 0);
    tick();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_error", rsp_error, 0);
    check("rsp_rdata", rsp_readdata, exp_rd);
    check("released_cs", avm_chipselect, 0);
    check("released_strobes", {avm_write_n, avm_read_n}, 2'b11);
    tick();
    check("rsp_pulse_end", rsp_valid, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  logic        bb_wr   [3] = '{1'b1, 1'b0, 1'b0};
  logic [1:0]  bb_addr [3] = '{2'd0, 2'd0, 2'd1};
  logic [31:0] bb_data [3] = '{32'h11, 32'h0, 32'h0};
  logic [31:0] bb_exp  [3] = '{32'h0, 32'h11, 32'h0};

  initial begin
    int idx, nrsp, w0;
    int hs_cyc[$];
    logic hs;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_address = 2'd0; cmd_writedata = 32'h0; waitreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_rdata", rsp_readdata, 0);
    check("rst_cs", avm_chipselect, 0);
    check("rst_strobes", {avm_write_n, avm_read_n}, 2'b11);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    reset_n = 1'b1;
    tick();

    // Basic write, readback, and unmapped read.
    run_cmd(1'b1, 2'd0, 32'h0000_00A5, 32'h0);
    check("pio_after_write", pio_out, 8'hA5);
    check("pio_write_count", pio_writes, 1);
    run_cmd(1'b0, 2'd0, 32'h0, 32'h0000_00A5);
    run_cmd(1'b0, 2'd1, 32'h0, 32'h0);

    // Write stalled for 3 cycles: bus stable 4 cycles, response at N+5.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h3C;
    tick();
    cmd_valid = 1'b0; cmd_writedata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      waitreq = (i < 3);
      check("wait_cs", avm_chipselect, 1);
      check("wait_write_n", avm_write_n, 0);
      check("wait_wdata", avm_writedata, 32'h3C);
      check("wait_no_rsp", rsp_valid, 0);
      tick();
    end
    check("wait_rsp_valid", rsp_valid, 1);
    check("wait_rsp_error", rsp_error, 0);
    check("wait_pio", pio_out, 8'h3C);
    check("wait_single_latch", pio_writes, 2);
    tick();

    // Timeout: waitrequest stuck, TIMEOUT=4 ACCESS cycles then error.
    waitreq = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_cs", avm_chipselect, 1);
      check("to_read_n", avm_read_n, 0);
      check("to_no_rsp", rsp_valid, 0);
      tick();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_error", rsp_error, 1);
    check("to_rsp_rdata", rsp_readdata, 0);
    check("to_released_cs", avm_chipselect, 0);
    check("to_released_read_n", avm_read_n, 1);
    waitreq = 1'b0;
    tick();
    run_cmd(1'b0, 2'd0, 32'h0, 32'h3C);

    // Back-to-back commands with cmd_valid held high.
    idx = 0; nrsp = 0;
    cmd_valid = 1'b1; cmd_write = bb_wr[0]; cmd_address = bb_addr[0]; cmd_writedata = bb_data[0];
    for (int c = 0; c < 20; c++) begin
      hs = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        if (nrsp < 3) begin
          check("b2b_rdata", rsp_readdata, bb_exp[nrsp]);
          check("b2b_error", rsp_error, 0);
        end
        nrsp++;
      end
      if (hs) hs_cyc.push_back(c);
      tick();
      if (hs) begin
        idx++;
        if (idx < 3) begin
          cmd_write = bb_wr[idx]; cmd_address = bb_addr[idx]; cmd_writedata = bb_data[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    check("b2b_rsp_count", nrsp, 3);
    check("b2b_hs_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3);
      check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end
    check("b2b_pio", pio_out, 8'h11);

    // Reset pulse mid-ACCESS drops the command.
    w0 = pio_writes;
    waitreq = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h77;
    tick();
    cmd_valid = 1'b0;
    check("rstmid_cs_before", avm_chipselect, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_cs", avm_chipselect, 0);
    check("rstmid_strobes", {avm_write_n, avm_read_n}, 2'b11);
    check("rstmid_ready", cmd_ready, 1);
    #2 reset_n = 1'b1;
    waitreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstmid_no_rsp", rsp_valid, 0);
      check("rstmid_idle_cs", avm_chipselect, 0);
    end
    check("rstmid_ready_after", cmd_ready, 1);
    check("rstmid_no_write", pio_writes, w0);
    check("rstmid_pio", pio_out, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
